// File: rtl/led_pkg.sv
// Shared types and helpers for the front-panel LED status scheduler.
// Holds the FSM state type, LED index/level constants and small helpers.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int GREEN  = 0;
    localparam int YELLOW = 1;
    localparam int ORANGE = 2;
    localparam int RED    = 3;

    localparam logic LED_ON  = 1'b0;
    localparam logic LED_OFF = 1'b1;

    // One-hot to index; a zero vector maps to index 0.
    function automatic logic [1:0] onehot2idx(input logic [3:0] oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/led_status_sched_rr_arb4.sv
// Four-way round-robin arbiter: search starts one past the pointer.
// Ports: i_pending[3:0], i_ptr[1:0] in; o_grant[3:0] one-hot, o_valid out.
import led_pkg::*;

module rr_arb4 (
    input  logic [3:0] i_pending,
    input  logic [1:0] i_ptr,
    output logic [3:0] o_grant,
    output logic       o_valid
);

    logic [1:0] w_idx;
    logic       w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= 4; k++) begin
            w_idx = i_ptr + 2'(k);
            if (!w_found && i_pending[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

    assign o_valid = |i_pending;

endmodule

// File: rtl/led_status_sched.sv
// Shares four panel LEDs between four event strobes, round-robin,
// with a stretched SHOW, a dark GAP and a green heartbeat when idle.
// Ports: clk, reset (async high), enable, lamp_test, req[3:0] in;
//        green/yellow/orange/red (active-low), busy, grant[3:0],
//        miss_cnt[7:0] out. All outputs are registered.
import led_pkg::*;

module led_status_sched #(
    parameter int unsigned STRETCH_BITS = 24,
    parameter int unsigned GAP_BITS     = 22,
    parameter int unsigned HB_BITS      = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       lamp_test,
    input  logic [3:0] req,
    output logic       green,
    output logic       yellow,
    output logic       orange,
    output logic       red,
    output logic       busy,
    output logic [3:0] grant,
    output logic [7:0] miss_cnt
);

    localparam int unsigned TW =
        (STRETCH_BITS > GAP_BITS) ? STRETCH_BITS : GAP_BITS;
    localparam logic [TW-1:0] SHOW_LAST =
        TW'((64'd1 << STRETCH_BITS) - 64'd1);
    localparam logic [TW-1:0] GAP_LAST =
        TW'((64'd1 << GAP_BITS) - 64'd1);

    state_t             r_state;
    logic [TW-1:0]      r_timer;
    logic [HB_BITS-1:0] r_hb;
    logic [3:0]         r_pending;
    logic [1:0]         r_rr_ptr;
    logic [3:0]         r_grant;
    logic [7:0]         r_miss;
    logic [3:0]         r_led;
    logic               r_busy;

    state_t             w_state_nxt;
    logic [TW-1:0]      w_timer_nxt;
    logic [HB_BITS-1:0] w_hb_nxt;
    logic [3:0]         w_pend_nxt;
    logic [1:0]         w_ptr_nxt;
    logic [3:0]         w_grant_nxt;
    logic [3:0]         w_clr;
    logic [3:0]         w_set;
    logic [3:0]         w_miss_hits;
    logic [8:0]         w_miss_sum;
    logic [7:0]         w_miss_nxt;
    logic [3:0]         w_led_nxt;
    logic [3:0]         w_arb_grant;
    logic               w_arb_valid;

    rr_arb4 u_arb (
        .i_pending (r_pending),
        .i_ptr     (r_rr_ptr),
        .o_grant   (w_arb_grant),
        .o_valid   (w_arb_valid)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_rr_ptr;
        w_clr       = '0;
        if (!enable) begin
            w_state_nxt = IDLE;
            w_timer_nxt = '0;
            w_grant_nxt = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_arb_valid) begin
                        w_state_nxt = SHOW;
                        w_timer_nxt = '0;
                        w_grant_nxt = w_arb_grant;
                        w_ptr_nxt   = onehot2idx(w_arb_grant);
                        w_clr       = w_arb_grant;
                    end
                end
                SHOW: begin
                    if (r_timer == SHOW_LAST) begin
                        w_state_nxt = GAP;
                        w_timer_nxt = '0;
                        w_grant_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                GAP: begin
                    if (r_timer == GAP_LAST) begin
                        w_state_nxt = IDLE;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_timer_nxt = '0;
                    w_grant_nxt = '0;
                end
            endcase
        end
    end

    // Set beats clear; a repeat strobe is lost only if the bit stays set.
    always_comb begin
        w_set       = req & {4{enable}};
        w_miss_hits = w_set & r_pending & ~w_clr;
        w_pend_nxt  = enable ? ((r_pending & ~w_clr) | w_set) : 4'd0;
        w_miss_sum  = {1'b0, r_miss} + {6'd0, popcount4(w_miss_hits)};
        w_miss_nxt  = w_miss_sum[8] ? 8'hFF : w_miss_sum[7:0];
    end

    assign w_hb_nxt = (enable && r_state == IDLE) ? r_hb + 1'b1 : r_hb;

    // LED levels are derived from the post-edge state so the pins
    // change on the same edge as the state they reflect.
    always_comb begin
        w_led_nxt = {4{LED_OFF}};
        unique case (w_state_nxt)
            IDLE: begin
                if (lamp_test) begin
                    w_led_nxt = {4{LED_ON}};
                end else if (enable) begin
                    w_led_nxt[GREEN] = ~w_hb_nxt[HB_BITS-1];
                end
            end
            SHOW:    w_led_nxt = ~w_grant_nxt;
            default: w_led_nxt = {4{LED_OFF}};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_hb      <= '0;
            r_pending <= '0;
            r_rr_ptr  <= 2'd3;
            r_grant   <= '0;
            r_miss    <= '0;
            r_led     <= {4{LED_OFF}};
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_hb      <= w_hb_nxt;
            r_pending <= w_pend_nxt;
            r_rr_ptr  <= w_ptr_nxt;
            r_grant   <= w_grant_nxt;
            r_miss    <= w_miss_nxt;
            r_led     <= w_led_nxt;
            r_busy    <= (w_state_nxt != IDLE);
        end
    end

    assign green    = r_led[GREEN];
    assign yellow   = r_led[YELLOW];
    assign orange   = r_led[ORANGE];
    assign red      = r_led[RED];
    assign busy     = r_busy;
    assign grant    = r_grant;
    assign miss_cnt = r_miss;

endmodule

// File: tb/tb_led_status_sched.sv
// Self-checking bench for led_status_sched with small timing parameters.
// Compares every cycle against an event-level model kept in the bench.
module tb_led_status_sched;

    localparam int SB = 4;
    localparam int GB = 2;
    localparam int HB = 3;
    localparam int SHOW_LEN = 1 << SB;
    localparam int GAP_LEN  = 1 << GB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       lamp_test = 1'b0;
    logic [3:0] req = 4'd0;
    logic       green, yellow, orange, red, busy;
    logic [3:0] grant;
    logic [7:0] miss_cnt;

    int checks = 0;
    int failures = 0;

    led_status_sched #(
        .STRETCH_BITS (SB),
        .GAP_BITS     (GB),
        .HB_BITS      (HB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .lamp_test (lamp_test),
        .req       (req),
        .green     (green),
        .yellow    (yellow),
        .orange    (orange),
        .red       (red),
        .busy      (busy),
        .grant     (grant),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 showing, 2 dark gap; m_rem = cycles left.
    int       m_mode, m_rem, m_ptr, m_win, m_miss, m_hb;
    bit [3:0] m_pend;
    bit       m_en, m_lt;

    function automatic void model_reset();
        m_mode = 0; m_rem = 0; m_ptr = 3; m_win = -1;
        m_miss = 0; m_hb = 0; m_pend = 0; m_en = 0; m_lt = 0;
    endfunction

    function automatic void model_step(bit en, bit lt, bit [3:0] rq);
        int clr;
        clr = -1;
        m_en = en; m_lt = lt;
        if (!en) begin
            m_mode = 0; m_rem = 0; m_win = -1; m_pend = 0;
            return;
        end
        case (m_mode)
            0: begin
                m_hb = (m_hb + 1) % (1 << HB);
                for (int k = 1; k <= 4; k++) begin
                    if (clr < 0 && m_pend[(m_ptr + k) % 4]) clr = (m_ptr + k) % 4;
                end
                if (clr >= 0) begin
                    m_mode = 1; m_rem = SHOW_LEN; m_win = clr; m_ptr = clr;
                end
            end
            1: begin
                m_rem--;
                if (m_rem == 0) begin
                    m_mode = 2; m_rem = GAP_LEN; m_win = -1;
                end
            end
            default: begin
                m_rem--;
                if (m_rem == 0) m_mode = 0;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            if (rq[i]) begin
                if (m_pend[i] && clr != i && m_miss < 255) m_miss++;
                m_pend[i] = 1'b1;
            end else if (clr == i) begin
                m_pend[i] = 1'b0;
            end
        end
    endfunction

    // {red, orange, yellow, green, busy, grant, miss}
    function automatic logic [16:0] exp_v();
        logic [3:0] l;
        logic [3:0] g;
        l = 4'hF; g = 4'h0;
        if (m_mode == 0) begin
            if (m_lt) l = 4'h0;
            else if (m_en) l[0] = ((m_hb >> (HB - 1)) & 1) ? 1'b0 : 1'b1;
        end else if (m_mode == 1) begin
            l[m_win] = 1'b0;
            g[m_win] = 1'b1;
        end
        return {l, (m_mode != 0), g, 8'(m_miss)};
    endfunction

    function automatic logic [16:0] obs_v();
        return {red, orange, yellow, green, busy, grant, miss_cnt};
    endfunction

    task automatic tick(input logic en, input logic lt, input logic [3:0] rq);
        enable = en; lamp_test = lt; req = rq;
        @(posedge clk);
        model_step(en, lt, rq);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b1; lamp_test = 1'b0; req = 4'd0;
        @(posedge clk); #1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        model_reset();
        checks++;
        if (obs_v() !== 17'h1E000) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", obs_v(), 17'h1E000);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_heartbeat();
        int toggles;
        logic prev;
        do_reset();
        toggles = 0; prev = green;
        for (int c = 0; c < 16; c++) begin
            tick(1, 0, 4'd0);
            checks++;
            if (obs_v() !== exp_v()) begin
                failures++;
                $display("FAIL heartbeat c=%0d got=%h exp=%h", c, obs_v(), exp_v());
            end
            if (green !== prev) toggles++;
            prev = green;
        end
        checks++;
        if (toggles !== 4) begin
            failures++;
            $display("FAIL hb_toggles got=%0d exp=4", toggles);
        end
    endtask

    task automatic test_single();
        int lit, bsy;
        do_reset();
        lit = 0; bsy = 0;
        tick(1, 0, 4'b0100);
        for (int c = 0; c < 26; c++) begin
            tick(1, 0, 4'd0);
            checks++;
            if (obs_v() !== exp_v()) begin
                failures++;
                $display("FAIL single c=%0d got=%h exp=%h", c, obs_v(), exp_v());
            end
            if (orange === 1'b0) lit++;
            if (busy === 1'b1) bsy++;
        end
        checks++;
        if (lit !== 16 || bsy !== 20) begin
            failures++;
            $display("FAIL single_len lit=%0d busy=%0d exp 16/20", lit, bsy);
        end
    endtask

    task automatic test_all_four();
        int order[$];
        logic [3:0] pg;
        do_reset();
        pg = 4'd0;
        tick(1, 0, 4'b1111);
        for (int c = 0; c < 4 * 21 + 4; c++) begin
            tick(1, 0, 4'd0);
            checks++;
            if (obs_v() !== exp_v()) begin
                failures++;
                $display("FAIL all_four c=%0d got=%h exp=%h", c, obs_v(), exp_v());
            end
            if (grant !== 4'd0 && grant !== pg) order.push_back(int'(grant));
            pg = grant;
        end
        checks++;
        if (order.size() != 4 || order[0] != 1 || order[1] != 2 ||
            order[2] != 4 || order[3] != 8 || miss_cnt !== 8'd0) begin
            failures++;
            $display("FAIL all_four_order n=%0d miss=%0d", order.size(), miss_cnt);
        end
    endtask

    task automatic test_miss();
        int red_lit;
        do_reset();
        red_lit = 0;
        tick(1, 0, 4'b0001);
        for (int c = 0; c < 60; c++) begin
            tick(1, 0, (c == 2 || c == 4 || c == 6) ? 4'b1000 : 4'd0);
            checks++;
            if (obs_v() !== exp_v()) begin
                failures++;
                $display("FAIL miss c=%0d got=%h exp=%h", c, obs_v(), exp_v());
            end
            if (red === 1'b0) red_lit++;
        end
        checks++;
        if (miss_cnt !== 8'd2 || red_lit !== 16) begin
            failures++;
            $display("FAIL miss_total miss=%0d red_lit=%0d exp 2/16", miss_cnt, red_lit);
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        tick(1, 0, 4'b0001);
        tick(1, 0, 4'd0);
        for (int c = 0; c < 7; c++) tick(1, 0, (c == 3) ? 4'b0010 : 4'd0);
        tick(0, 0, 4'd0);
        checks++;
        if (obs_v() !== {4'hF, 1'b0, 4'h0, 8'h00}) begin
            failures++;
            $display("FAIL en_drop got=%h exp=%h", obs_v(), {4'hF, 1'b0, 4'h0, 8'h00});
        end
        for (int c = 0; c < 3; c++) tick(0, 0, 4'd0);
        for (int c = 0; c < 12; c++) begin
            tick(1, 0, 4'd0);
            checks++;
            if (obs_v() !== exp_v()) begin
                failures++;
                $display("FAIL en_resume c=%0d got=%h exp=%h", c, obs_v(), exp_v());
            end
        end
    endtask

    task automatic test_lamp();
        do_reset();
        for (int c = 0; c < 3; c++) tick(1, 1, 4'd0);
        checks++;
        if ({red, orange, yellow, green} !== 4'h0) begin
            failures++;
            $display("FAIL lamp_idle got=%b exp=0000", {red, orange, yellow, green});
        end
        tick(0, 1, 4'd0);
        tick(1, 1, 4'b1000);
        for (int c = 0; c < 24; c++) begin
            tick(1, 1, 4'd0);
            checks++;
            if (obs_v() !== exp_v()) begin
                failures++;
                $display("FAIL lamp_show c=%0d got=%h exp=%h", c, obs_v(), exp_v());
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(1, 0, 4'b0010);
        for (int c = 0; c < 5; c++) tick(1, 0, 4'd0);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs_v() !== 17'h1E000) begin
            failures++;
            $display("FAIL async_show got=%h exp=%h", obs_v(), 17'h1E000);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        tick(1, 0, 4'b0100);
        for (int c = 0; c < SHOW_LEN + 2; c++) tick(1, 0, 4'd0);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs_v() !== 17'h1E000) begin
            failures++;
            $display("FAIL async_gap got=%h exp=%h", obs_v(), 17'h1E000);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_miss_saturate();
        do_reset();
        for (int c = 0; c < 120; c++) begin
            tick(1, 0, 4'b1111);
            checks++;
            if (obs_v() !== exp_v()) begin
                failures++;
                $display("FAIL sat c=%0d got=%h exp=%h", c, obs_v(), exp_v());
            end
        end
        checks++;
        if (miss_cnt !== 8'hFF) begin
            failures++;
            $display("FAIL sat_final got=%0d exp=255", miss_cnt);
        end
    endtask

    task automatic test_random();
        logic en, lt;
        logic [3:0] rq;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            en = ($urandom_range(0, 149) != 0);
            lt = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < 4; i++) rq[i] = ($urandom_range(0, 24) == 0);
            tick(en, lt, rq);
            checks++;
            if (obs_v() !== exp_v()) begin
                failures++;
                $display("FAIL random c=%0d got=%h exp=%h", c, obs_v(), exp_v());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_heartbeat();
        test_single();
        test_all_four();
        test_miss();
        test_enable_drop();
        test_lamp();
        test_async_reset();
        test_miss_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
